// File: rtl/pipeline_debug_database.sv
// Debug snapshot mux: packs MIPS pipeline stage state into 32-bit words and
// registers the word picked by i_control onto o_dato for the debug unit to stream out.
module pipeline_debug_database #(
    parameter int ADDR_LENGTH                     = 10,
    parameter int LONGITUD_INSTRUCCION            = 32,
    parameter int CANT_BITS_CONTROL               = 4,
    parameter int CANT_BITS_REGISTROS             = 32,
    parameter int CANT_BITS_ALU_OP                = 2,
    parameter int CANT_BITS_ALU_CONTROL           = 4,
    parameter int CANT_REGISTROS                  = 32,
    parameter int CANT_BITS_SELECT_BYTES_MEM_DATA = 3,
    parameter int WIDTH_DATA_MEM                  = 32,
    parameter int CANT_BITS_FLAG_BRANCH           = 3,
    localparam int RW                             = $clog2(CANT_REGISTROS)
) (
    input  logic                                       i_clock,
    input  logic                                       i_soft_reset,
    input  logic [CANT_BITS_CONTROL-1:0]               i_control,
    // PC / fetch
    input  logic [ADDR_LENGTH-1:0]                     i_pc,
    input  logic [ADDR_LENGTH-1:0]                     i_adder_pc,
    input  logic [ADDR_LENGTH-1:0]                     i_contador_ciclos,
    input  logic [LONGITUD_INSTRUCCION-1:0]            i_instruction_fetch,
    // IF/ID and ID
    input  logic [ADDR_LENGTH-1:0]                     i_branch_dir_ID,
    input  logic                                       i_branch_control_ID,
    input  logic [CANT_BITS_FLAG_BRANCH-1:0]           i_flag_branch,
    input  logic [CANT_BITS_REGISTROS-1:0]             i_data_A,
    input  logic [CANT_BITS_REGISTROS-1:0]             i_data_B,
    input  logic [CANT_BITS_REGISTROS-1:0]             i_extension_signo_constante,
    input  logic [RW-1:0]                              i_reg_rs,
    input  logic [RW-1:0]                              i_reg_rt,
    input  logic [RW-1:0]                              i_reg_rd,
    // ID/EX
    input  logic                                       i_RegDst,
    input  logic                                       i_RegWrite_ID_to_EX,
    input  logic                                       i_ALUSrc,
    input  logic                                       i_MemRead_ID_to_EX,
    input  logic                                       i_MemWrite_ID_to_EX,
    input  logic                                       i_MemtoReg_ID_to_EX,
    input  logic                                       i_halt_detected_ID_to_EX,
    input  logic [CANT_BITS_ALU_OP-1:0]                i_ALUOp,
    input  logic [CANT_BITS_ALU_CONTROL-1:0]           i_ALUCtrl,
    input  logic [CANT_BITS_SELECT_BYTES_MEM_DATA-1:0] i_select_bytes_mem_data_ID_to_EX,
    // EX/MEM
    input  logic                                       i_RegWrite_EX_to_MEM,
    input  logic                                       i_MemRead_EX_to_MEM,
    input  logic                                       i_MemWrite_EX_to_MEM,
    input  logic                                       i_MemtoReg_EX_to_MEM,
    input  logic                                       i_halt_detected_EX_to_MEM,
    input  logic [CANT_BITS_SELECT_BYTES_MEM_DATA-1:0] i_select_bytes_mem_datos_EX_to_MEM,
    input  logic [RW-1:0]                              i_registro_destino_EX_to_MEM,
    input  logic [CANT_BITS_REGISTROS-1:0]             i_result_alu,
    input  logic [WIDTH_DATA_MEM-1:0]                  i_data_write_to_mem,
    input  logic [ADDR_LENGTH-1:0]                     i_branch_dir_EX,
    input  logic [1:0]                                 i_branch_control_EX,
    // MEM/WB
    input  logic                                       i_RegWrite_MEM_to_WB,
    input  logic                                       i_MemtoReg_MEM_to_WB,
    input  logic                                       i_halt_detected_MEM_to_WB,
    input  logic [RW-1:0]                              i_registro_destino_MEM_to_WB,
    input  logic [CANT_BITS_REGISTROS-1:0]             i_data_alu_MEM_to_WB,
    input  logic [WIDTH_DATA_MEM-1:0]                  i_data_mem_MEM_to_WB,
    input  logic                                       i_halt_detected_WB_to_Debug_Unit,
    output logic [LONGITUD_INSTRUCCION-1:0]            o_dato
);

    localparam int LI = LONGITUD_INSTRUCCION;
    localparam int CB = CANT_BITS_CONTROL;

    localparam logic [CB-1:0] SEL_PC        = CB'(0);
    localparam logic [CB-1:0] SEL_ADDER_PC  = CB'(1);
    localparam logic [CB-1:0] SEL_INSTR     = CB'(2);
    localparam logic [CB-1:0] SEL_CICLOS    = CB'(3);
    localparam logic [CB-1:0] SEL_ID_REGS   = CB'(4);
    localparam logic [CB-1:0] SEL_DATA_A    = CB'(5);
    localparam logic [CB-1:0] SEL_DATA_B    = CB'(6);
    localparam logic [CB-1:0] SEL_EXT_SIGNO = CB'(7);
    localparam logic [CB-1:0] SEL_ID_EX     = CB'(8);
    localparam logic [CB-1:0] SEL_EX_MEM    = CB'(9);
    localparam logic [CB-1:0] SEL_ALU       = CB'(10);
    localparam logic [CB-1:0] SEL_DATA_WR   = CB'(11);
    localparam logic [CB-1:0] SEL_MEM_WB    = CB'(12);
    localparam logic [CB-1:0] SEL_WB_ALU    = CB'(13);
    localparam logic [CB-1:0] SEL_WB_MEM    = CB'(14);

    logic [LI-1:0] dato_d;
    logic [LI-1:0] dato_q;

    // Concatenations list fields MSB-first; the size cast zero-extends or truncates to the word.
    always_comb begin
        dato_d = '0;
        case (i_control)
            SEL_PC:        dato_d = LI'(i_pc);
            SEL_ADDER_PC:  dato_d = LI'(i_adder_pc);
            SEL_INSTR:     dato_d = LI'(i_instruction_fetch);
            SEL_CICLOS:    dato_d = LI'(i_contador_ciclos);
            SEL_ID_REGS:   dato_d = LI'({i_branch_control_ID, i_flag_branch, i_branch_dir_ID,
                                         i_reg_rs, i_reg_rt, i_reg_rd});
            SEL_DATA_A:    dato_d = LI'(i_data_A);
            SEL_DATA_B:    dato_d = LI'(i_data_B);
            SEL_EXT_SIGNO: dato_d = LI'(i_extension_signo_constante);
            SEL_ID_EX:     dato_d = LI'({i_RegDst, i_RegWrite_ID_to_EX, i_ALUSrc, i_ALUOp,
                                         i_MemRead_ID_to_EX, i_MemWrite_ID_to_EX,
                                         i_MemtoReg_ID_to_EX, i_ALUCtrl,
                                         i_select_bytes_mem_data_ID_to_EX,
                                         i_halt_detected_ID_to_EX});
            SEL_EX_MEM:    dato_d = LI'({i_RegWrite_EX_to_MEM, i_MemRead_EX_to_MEM,
                                         i_MemWrite_EX_to_MEM, i_MemtoReg_EX_to_MEM,
                                         i_select_bytes_mem_datos_EX_to_MEM,
                                         i_halt_detected_EX_to_MEM,
                                         i_registro_destino_EX_to_MEM,
                                         i_branch_control_EX, i_branch_dir_EX});
            SEL_ALU:       dato_d = LI'(i_result_alu);
            SEL_DATA_WR:   dato_d = LI'(i_data_write_to_mem);
            SEL_MEM_WB:    dato_d = LI'({i_RegWrite_MEM_to_WB, i_MemtoReg_MEM_to_WB,
                                         i_halt_detected_MEM_to_WB,
                                         i_registro_destino_MEM_to_WB,
                                         i_halt_detected_WB_to_Debug_Unit});
            SEL_WB_ALU:    dato_d = LI'(i_data_alu_MEM_to_WB);
            SEL_WB_MEM:    dato_d = LI'(i_data_mem_MEM_to_WB);
            default:       dato_d = '0;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_soft_reset) begin
            dato_q <= '0;
        end else begin
            dato_q <= dato_d;
        end
    end

    assign o_dato = dato_q;

endmodule

// File: tb/tb_pipeline_debug_database.sv
// Self-checking bench for pipeline_debug_database: table of plain-word selections,
// hand sequences for packed words and reset, and a randomized packed-field loop.
module tb_pipeline_debug_database;

    logic        i_clock = 1'b0;
    logic        i_soft_reset;
    logic [3:0]  i_control;
    logic [9:0]  i_pc, i_adder_pc, i_contador_ciclos, i_branch_dir_ID, i_branch_dir_EX;
    logic [31:0] i_instruction_fetch, i_data_A, i_data_B, i_extension_signo_constante;
    logic [31:0] i_result_alu, i_data_write_to_mem, i_data_alu_MEM_to_WB, i_data_mem_MEM_to_WB;
    logic        i_branch_control_ID;
    logic [2:0]  i_flag_branch;
    logic [4:0]  i_reg_rs, i_reg_rt, i_reg_rd, i_registro_destino_EX_to_MEM, i_registro_destino_MEM_to_WB;
    logic        i_RegDst, i_RegWrite_ID_to_EX, i_ALUSrc, i_MemRead_ID_to_EX, i_MemWrite_ID_to_EX;
    logic        i_MemtoReg_ID_to_EX, i_halt_detected_ID_to_EX;
    logic [1:0]  i_ALUOp;
    logic [3:0]  i_ALUCtrl;
    logic [2:0]  i_select_bytes_mem_data_ID_to_EX, i_select_bytes_mem_datos_EX_to_MEM;
    logic        i_RegWrite_EX_to_MEM, i_MemRead_EX_to_MEM, i_MemWrite_EX_to_MEM, i_MemtoReg_EX_to_MEM;
    logic        i_halt_detected_EX_to_MEM;
    logic [1:0]  i_branch_control_EX;
    logic        i_RegWrite_MEM_to_WB, i_MemtoReg_MEM_to_WB, i_halt_detected_MEM_to_WB;
    logic        i_halt_detected_WB_to_Debug_Unit;
    logic [31:0] o_dato;

    pipeline_debug_database dut (
        .i_clock(i_clock), .i_soft_reset(i_soft_reset), .i_control(i_control),
        .i_pc(i_pc), .i_adder_pc(i_adder_pc), .i_contador_ciclos(i_contador_ciclos),
        .i_instruction_fetch(i_instruction_fetch),
        .i_branch_dir_ID(i_branch_dir_ID), .i_branch_control_ID(i_branch_control_ID),
        .i_flag_branch(i_flag_branch),
        .i_data_A(i_data_A), .i_data_B(i_data_B),
        .i_extension_signo_constante(i_extension_signo_constante),
        .i_reg_rs(i_reg_rs), .i_reg_rt(i_reg_rt), .i_reg_rd(i_reg_rd),
        .i_RegDst(i_RegDst), .i_RegWrite_ID_to_EX(i_RegWrite_ID_to_EX), .i_ALUSrc(i_ALUSrc),
        .i_MemRead_ID_to_EX(i_MemRead_ID_to_EX), .i_MemWrite_ID_to_EX(i_MemWrite_ID_to_EX),
        .i_MemtoReg_ID_to_EX(i_MemtoReg_ID_to_EX), .i_halt_detected_ID_to_EX(i_halt_detected_ID_to_EX),
        .i_ALUOp(i_ALUOp), .i_ALUCtrl(i_ALUCtrl),
        .i_select_bytes_mem_data_ID_to_EX(i_select_bytes_mem_data_ID_to_EX),
        .i_RegWrite_EX_to_MEM(i_RegWrite_EX_to_MEM), .i_MemRead_EX_to_MEM(i_MemRead_EX_to_MEM),
        .i_MemWrite_EX_to_MEM(i_MemWrite_EX_to_MEM), .i_MemtoReg_EX_to_MEM(i_MemtoReg_EX_to_MEM),
        .i_halt_detected_EX_to_MEM(i_halt_detected_EX_to_MEM),
        .i_select_bytes_mem_datos_EX_to_MEM(i_select_bytes_mem_datos_EX_to_MEM),
        .i_registro_destino_EX_to_MEM(i_registro_destino_EX_to_MEM),
        .i_result_alu(i_result_alu), .i_data_write_to_mem(i_data_write_to_mem),
        .i_branch_dir_EX(i_branch_dir_EX), .i_branch_control_EX(i_branch_control_EX),
        .i_RegWrite_MEM_to_WB(i_RegWrite_MEM_to_WB), .i_MemtoReg_MEM_to_WB(i_MemtoReg_MEM_to_WB),
        .i_halt_detected_MEM_to_WB(i_halt_detected_MEM_to_WB),
        .i_registro_destino_MEM_to_WB(i_registro_destino_MEM_to_WB),
        .i_data_alu_MEM_to_WB(i_data_alu_MEM_to_WB), .i_data_mem_MEM_to_WB(i_data_mem_MEM_to_WB),
        .i_halt_detected_WB_to_Debug_Unit(i_halt_detected_WB_to_Debug_Unit),
        .o_dato(o_dato)
    );

    always #5 i_clock = ~i_clock;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;

    typedef struct {
        string       name;
        logic [3:0]  ctrl;
        logic [9:0]  pc, adder, cyc;
        logic [31:0] instr, a, b, ext, alu, dwm, dalu, dmem;
        logic [31:0] exp;
    } vec_t;

    sb_t  sb_q[$];
    vec_t tbl[16];
    int   checks = 0;
    int   errors = 0;

    // Drive is done by the caller just after an edge; this pushes the expectation,
    // lets one edge pass, then pops and compares away from the edge.
    task automatic step(input string name, input logic [31:0] exp);
        sb_t e;
        sb_q.push_back('{name, exp});
        @(posedge i_clock);
        #1;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty", name);
        end else begin
            e = sb_q.pop_front();
            checks++;
            if (o_dato !== e.exp) begin
                errors++;
                $display("FAIL %s got %h expected %h", e.name, o_dato, e.exp);
            end
        end
    endtask

    task automatic clear_packed();
        {i_branch_dir_ID, i_branch_control_ID, i_flag_branch, i_reg_rs, i_reg_rt, i_reg_rd} = '0;
        {i_RegDst, i_RegWrite_ID_to_EX, i_ALUSrc, i_MemRead_ID_to_EX, i_MemWrite_ID_to_EX} = '0;
        {i_MemtoReg_ID_to_EX, i_halt_detected_ID_to_EX, i_ALUOp, i_ALUCtrl} = '0;
        i_select_bytes_mem_data_ID_to_EX = '0;
        {i_RegWrite_EX_to_MEM, i_MemRead_EX_to_MEM, i_MemWrite_EX_to_MEM, i_MemtoReg_EX_to_MEM} = '0;
        {i_halt_detected_EX_to_MEM, i_select_bytes_mem_datos_EX_to_MEM} = '0;
        {i_registro_destino_EX_to_MEM, i_branch_dir_EX, i_branch_control_EX} = '0;
        {i_RegWrite_MEM_to_WB, i_MemtoReg_MEM_to_WB, i_halt_detected_MEM_to_WB} = '0;
        {i_registro_destino_MEM_to_WB, i_halt_detected_WB_to_Debug_Unit} = '0;
    endtask

    task automatic set_packed(input logic v);
        {i_branch_dir_ID, i_branch_control_ID, i_flag_branch, i_reg_rs, i_reg_rt, i_reg_rd} = {29{v}};
        {i_RegDst, i_RegWrite_ID_to_EX, i_ALUSrc, i_MemRead_ID_to_EX, i_MemWrite_ID_to_EX} = {5{v}};
        {i_MemtoReg_ID_to_EX, i_halt_detected_ID_to_EX, i_ALUOp, i_ALUCtrl} = {8{v}};
        i_select_bytes_mem_data_ID_to_EX = {3{v}};
        {i_RegWrite_EX_to_MEM, i_MemRead_EX_to_MEM, i_MemWrite_EX_to_MEM, i_MemtoReg_EX_to_MEM} = {4{v}};
        {i_halt_detected_EX_to_MEM, i_select_bytes_mem_datos_EX_to_MEM} = {4{v}};
        {i_registro_destino_EX_to_MEM, i_branch_dir_EX, i_branch_control_EX} = {17{v}};
        {i_RegWrite_MEM_to_WB, i_MemtoReg_MEM_to_WB, i_halt_detected_MEM_to_WB} = {3{v}};
        {i_registro_destino_MEM_to_WB, i_halt_detected_WB_to_Debug_Unit} = {6{v}};
    endtask

    function automatic logic [31:0] model_packed(input logic [3:0] c);
        logic [31:0] m;
        m = 32'h0;
        case (c)
            4'd4:  m = 32'(i_reg_rd) | (32'(i_reg_rt) << 5) | (32'(i_reg_rs) << 10)
                     | (32'(i_branch_dir_ID) << 15) | (32'(i_flag_branch) << 25)
                     | (32'(i_branch_control_ID) << 28);
            4'd8:  m = 32'(i_halt_detected_ID_to_EX) | (32'(i_select_bytes_mem_data_ID_to_EX) << 1)
                     | (32'(i_ALUCtrl) << 4) | (32'(i_MemtoReg_ID_to_EX) << 8)
                     | (32'(i_MemWrite_ID_to_EX) << 9) | (32'(i_MemRead_ID_to_EX) << 10)
                     | (32'(i_ALUOp) << 11) | (32'(i_ALUSrc) << 13)
                     | (32'(i_RegWrite_ID_to_EX) << 14) | (32'(i_RegDst) << 15);
            4'd9:  m = 32'(i_branch_dir_EX) | (32'(i_branch_control_EX) << 10)
                     | (32'(i_registro_destino_EX_to_MEM) << 12) | (32'(i_halt_detected_EX_to_MEM) << 17)
                     | (32'(i_select_bytes_mem_datos_EX_to_MEM) << 18) | (32'(i_MemtoReg_EX_to_MEM) << 21)
                     | (32'(i_MemWrite_EX_to_MEM) << 22) | (32'(i_MemRead_EX_to_MEM) << 23)
                     | (32'(i_RegWrite_EX_to_MEM) << 24);
            4'd12: m = 32'(i_halt_detected_WB_to_Debug_Unit) | (32'(i_registro_destino_MEM_to_WB) << 1)
                     | (32'(i_halt_detected_MEM_to_WB) << 6) | (32'(i_MemtoReg_MEM_to_WB) << 7)
                     | (32'(i_RegWrite_MEM_to_WB) << 8);
            default: m = 32'h0;
        endcase
        return m;
    endfunction

    initial begin
        logic [3:0] rsel [4];
        rsel[0] = 4'd4; rsel[1] = 4'd8; rsel[2] = 4'd9; rsel[3] = 4'd12;

        //          name        ctrl  pc      adder   cyc     instr         a             b             ext           alu           dwm           dalu          dmem          exp
        tbl[0]  = '{"spec_pc",    4'd0,  10'd4,  10'd8,  10'd0,  32'd2,        32'd2,        32'd0,        32'd0,        32'd5,        32'd6,        32'd0,        32'd0,        32'd4};
        tbl[1]  = '{"spec_adder", 4'd1,  10'd4,  10'd8,  10'd0,  32'd2,        32'd2,        32'd0,        32'd0,        32'd5,        32'd6,        32'd0,        32'd0,        32'd8};
        tbl[2]  = '{"spec_instr", 4'd2,  10'd4,  10'd8,  10'd0,  32'd2,        32'd2,        32'd0,        32'd0,        32'd5,        32'd6,        32'd0,        32'd0,        32'd2};
        tbl[3]  = '{"spec_dataA", 4'd5,  10'd4,  10'd8,  10'd0,  32'd2,        32'd2,        32'd0,        32'd0,        32'd5,        32'd6,        32'd0,        32'd0,        32'd2};
        tbl[4]  = '{"spec_alu",   4'd10, 10'd4,  10'd8,  10'd0,  32'd2,        32'd2,        32'd0,        32'd0,        32'd5,        32'd6,        32'd0,        32'd0,        32'd5};
        tbl[5]  = '{"pc_max",     4'd0,  10'h3FF,10'h2AA,10'h155,32'hDEADBEEF, 32'h11111111, 32'h22222222, 32'hFFFF8000, 32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888, 32'h000003FF};
        tbl[6]  = '{"adder",      4'd1,  10'h3FF,10'h2AA,10'h155,32'hDEADBEEF, 32'h11111111, 32'h22222222, 32'hFFFF8000, 32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888, 32'h000002AA};
        tbl[7]  = '{"instr",      4'd2,  10'h3FF,10'h2AA,10'h155,32'hDEADBEEF, 32'h11111111, 32'h22222222, 32'hFFFF8000, 32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888, 32'hDEADBEEF};
        tbl[8]  = '{"ciclos",     4'd3,  10'h3FF,10'h2AA,10'h155,32'hDEADBEEF, 32'h11111111, 32'h22222222, 32'hFFFF8000, 32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888, 32'h00000155};
        tbl[9]  = '{"dataB",      4'd6,  10'h3FF,10'h2AA,10'h155,32'hDEADBEEF, 32'h11111111, 32'h22222222, 32'hFFFF8000, 32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888, 32'h22222222};
        tbl[10] = '{"ext_signo",  4'd7,  10'h3FF,10'h2AA,10'h155,32'hDEADBEEF, 32'h11111111, 32'h22222222, 32'hFFFF8000, 32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888, 32'hFFFF8000};
        tbl[11] = '{"data_wr",    4'd11, 10'h3FF,10'h2AA,10'h155,32'hDEADBEEF, 32'h11111111, 32'h22222222, 32'hFFFF8000, 32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888, 32'h66666666};
        tbl[12] = '{"wb_alu",     4'd13, 10'h3FF,10'h2AA,10'h155,32'hDEADBEEF, 32'h11111111, 32'h22222222, 32'hFFFF8000, 32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888, 32'h77777777};
        tbl[13] = '{"wb_mem",     4'd14, 10'h3FF,10'h2AA,10'h155,32'hDEADBEEF, 32'h11111111, 32'h22222222, 32'hFFFF8000, 32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888, 32'h88888888};
        tbl[14] = '{"sel15_zero", 4'd15, 10'h3FF,10'h2AA,10'h155,32'hDEADBEEF, 32'h11111111, 32'h22222222, 32'hFFFF8000, 32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888, 32'h00000000};
        tbl[15] = '{"alu",        4'd10, 10'h3FF,10'h2AA,10'h155,32'hDEADBEEF, 32'h11111111, 32'h22222222, 32'hFFFF8000, 32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888, 32'h55555555};

        i_soft_reset = 1'b1;
        i_control = 4'd2;
        i_pc = '0; i_adder_pc = '0; i_contador_ciclos = '0;
        i_instruction_fetch = 32'hCAFEF00D;
        i_data_A = '0; i_data_B = '0; i_extension_signo_constante = '0;
        i_result_alu = '0; i_data_write_to_mem = '0; i_data_alu_MEM_to_WB = '0; i_data_mem_MEM_to_WB = '0;
        set_packed(1'b1);

        // Reset held over several edges with a nonzero word selected.
        for (int i = 0; i < 3; i++) step("reset_hold", 32'h0);

        i_soft_reset = 1'b0;
        i_control = 4'd0;
        i_pc = 10'd4;
        step("reset_release_pc", 32'd4);
        clear_packed();

        for (int i = 0; i < 16; i++) begin
            i_control = tbl[i].ctrl;
            i_pc = tbl[i].pc; i_adder_pc = tbl[i].adder; i_contador_ciclos = tbl[i].cyc;
            i_instruction_fetch = tbl[i].instr;
            i_data_A = tbl[i].a; i_data_B = tbl[i].b; i_extension_signo_constante = tbl[i].ext;
            i_result_alu = tbl[i].alu; i_data_write_to_mem = tbl[i].dwm;
            i_data_alu_MEM_to_WB = tbl[i].dalu; i_data_mem_MEM_to_WB = tbl[i].dmem;
            step(tbl[i].name, tbl[i].exp);
        end

        // Packed words from known field values.
        clear_packed();
        i_control = 4'd4;
        i_reg_rd = 5'd7; i_reg_rt = 5'd6; i_reg_rs = 5'd5;
        i_branch_dir_ID = 10'd1; i_flag_branch = 3'd0; i_branch_control_ID = 1'b1;
        step("id_regs", 32'h100094C7);

        clear_packed();
        i_control = 4'd8;
        i_RegDst = 1'b1; i_ALUOp = 2'd2; i_MemWrite_ID_to_EX = 1'b1; i_ALUCtrl = 4'd4;
        i_select_bytes_mem_data_ID_to_EX = 3'd2; i_halt_detected_ID_to_EX = 1'b1;
        step("id_ex", 32'h00009245);

        clear_packed();
        i_control = 4'd9;
        i_branch_dir_EX = 10'd4; i_branch_control_EX = 2'd0; i_registro_destino_EX_to_MEM = 5'd1;
        i_select_bytes_mem_datos_EX_to_MEM = 3'd3; i_MemtoReg_EX_to_MEM = 1'b1; i_MemRead_EX_to_MEM = 1'b1;
        step("ex_mem", 32'h00AC1004);

        clear_packed();
        i_control = 4'd12;
        i_halt_detected_WB_to_Debug_Unit = 1'b1; i_registro_destino_MEM_to_WB = 5'h1F;
        i_MemtoReg_MEM_to_WB = 1'b1; i_RegWrite_MEM_to_WB = 1'b1;
        step("mem_wb", 32'h000001BF);

        // All fields ones: upper unused bits must stay zero.
        set_packed(1'b1);
        i_control = 4'd4;  step("id_regs_ones", 32'h1FFFFFFF);
        i_control = 4'd8;  step("id_ex_ones",   32'h0000FFFF);
        i_control = 4'd9;  step("ex_mem_ones",  32'h01FFFFFF);
        i_control = 4'd12; step("mem_wb_ones",  32'h000001FF);
        i_control = 4'd15; step("sel15_ones",   32'h00000000);

        // Reset in the middle of a sweep.
        i_control = 4'd11; i_data_write_to_mem = 32'd6;
        step("sweep_dwr", 32'd6);
        i_soft_reset = 1'b1;
        step("sweep_reset", 32'd0);
        i_soft_reset = 1'b0;
        step("sweep_resume", 32'd6);

        for (int i = 0; i < 24; i++) begin
            {i_branch_dir_ID, i_branch_control_ID, i_flag_branch, i_reg_rs, i_reg_rt, i_reg_rd} = 29'($urandom);
            {i_RegDst, i_RegWrite_ID_to_EX, i_ALUSrc, i_MemRead_ID_to_EX, i_MemWrite_ID_to_EX,
             i_MemtoReg_ID_to_EX, i_halt_detected_ID_to_EX, i_ALUOp, i_ALUCtrl,
             i_select_bytes_mem_data_ID_to_EX} = 16'($urandom);
            {i_RegWrite_EX_to_MEM, i_MemRead_EX_to_MEM, i_MemWrite_EX_to_MEM, i_MemtoReg_EX_to_MEM,
             i_halt_detected_EX_to_MEM, i_select_bytes_mem_datos_EX_to_MEM,
             i_registro_destino_EX_to_MEM, i_branch_dir_EX, i_branch_control_EX} = 25'($urandom);
            {i_RegWrite_MEM_to_WB, i_MemtoReg_MEM_to_WB, i_halt_detected_MEM_to_WB,
             i_registro_destino_MEM_to_WB, i_halt_detected_WB_to_Debug_Unit} = 9'($urandom);
            i_control = rsel[i % 4];
            step($sformatf("rand_packed_sel%0d", i_control), model_packed(i_control));
        end

        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d expected 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
